letc_core_stage_fetch2: RTL and testbench

Second fetch stage of the LETC core pipeline, between fetch stage 1 (issues instruction-memory requests) and the decode stage (consumes `f2_to_d`). It tracks at most one outstanding fetch, captures the instruction-memory response, and presents a registered `f2_to_d` word plus valid to decode. It honours the pipeline stall and flush controls, including discarding responses for requests that a flush has squashed.

---
 rtl/letc_core_stage_fetch2.sv | 145 ++++++++++++++
 tb/tb_letc_core_stage_fetch2.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/letc_core_stage_fetch2.sv
// Second fetch stage: tracks one outstanding imem request, captures its response
// and presents a registered f2_to_d word to decode, honouring stall and flush.
package letc_pkg;
  typedef logic [31:0] word_t;
endpackage

package letc_core_pkg;
  import letc_pkg::*;

  typedef struct packed {
    word_t pc;
  } f1_to_f2_s;

  typedef struct packed {
    word_t       pc;
    logic [31:0] instr;
    logic        fetch_fault;
  } f2_to_d_s;
endpackage

module letc_core_stage_fetch2
  import letc_pkg::*;
  import letc_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        stage_ready,
  input  logic        stage_flush,
  input  logic        stage_stall,
  input  logic        f1_to_f2_valid,
  input  f1_to_f2_s   f1_to_f2,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_instr,
  input  logic        imem_rsp_fault,
  output logic        f2_to_d_valid,
  output f2_to_d_s    f2_to_d,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_e   state_q, state_d;
  word_t    pc_q, pc_d;
  logic     hold_valid_q, hold_valid_d;
  f2_to_d_s hold_q, hold_d;
  logic     out_valid_q, out_valid_d;
  f2_to_d_s out_q, out_d;

  logic     rsp_in_wait;
  logic     accept;
  f2_to_d_s rsp_word;

  // Handshake: f1 -> f2 transfers when f1_to_f2_valid && stage_ready on a rising
  // edge; stage_ready never depends on f1_to_f2_valid, and decode consumes
  // f2_to_d whenever f2_to_d_valid is high and stage_stall is low.
  assign rsp_in_wait = (state_q == WAIT) && imem_rsp_valid;
  assign stage_ready = !stage_flush && !hold_valid_q &&
                       ((state_q == IDLE) || (rsp_in_wait && !stage_stall));
  assign accept      = f1_to_f2_valid && stage_ready;

  // Faulting fetches become a nop so decode has no side effects to suppress.
  always_comb begin
    rsp_word             = '0;
    rsp_word.pc          = pc_q;
    rsp_word.instr       = imem_rsp_fault ? NOP_INSTR : imem_rsp_instr;
    rsp_word.fetch_fault = imem_rsp_fault;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = WAIT;
      end
      WAIT: begin
        if (stage_flush)         state_d = imem_rsp_valid ? IDLE : DRAIN;
        else if (imem_rsp_valid) state_d = accept ? WAIT : IDLE;
      end
      DRAIN: begin
        if (imem_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d         = accept ? f1_to_f2.pc : pc_q;
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    if (stage_flush) begin
      out_valid_d  = 1'b0;
      hold_valid_d = 1'b0;
    end else if (stage_stall) begin
      if (rsp_in_wait) begin
        hold_valid_d = 1'b1;
        hold_d       = rsp_word;
      end
    end else if (hold_valid_q) begin
      out_valid_d  = 1'b1;
      out_d        = hold_q;
      hold_valid_d = 1'b0;
    end else if (rsp_in_wait) begin
      out_valid_d = 1'b1;
      out_d       = rsp_word;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
    end
  end

  assign f2_to_d_valid = out_valid_q;
  assign f2_to_d       = out_q;
  assign dbg_state_o   = state_q;

  // A response with nothing outstanding means the memory side broke protocol.
  assert property (@(posedge clk) disable iff (rst)
                   !((state_q == IDLE) && imem_rsp_valid))
    else $error("imem response received with no request outstanding");

endmodule

// File: tb/tb_letc_core_stage_fetch2.sv
// Directed bench for letc_core_stage_fetch2: vector table plus hand-written
// reset sequences, each step checking stage_ready and the registered output.
module tb_letc_core_stage_fetch2;
  import letc_pkg::*;
  import letc_core_pkg::*;

  logic        clk;
  logic        rst;
  logic        stage_ready;
  logic        stage_flush;
  logic        stage_stall;
  logic        f1_to_f2_valid;
  f1_to_f2_s   f1_to_f2;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_instr;
  logic        imem_rsp_fault;
  logic        f2_to_d_valid;
  f2_to_d_s    f2_to_d;
  logic [1:0]  dbg_state_o;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  letc_core_stage_fetch2 dut (
    .clk            (clk),
    .rst            (rst),
    .stage_ready    (stage_ready),
    .stage_flush    (stage_flush),
    .stage_stall    (stage_stall),
    .f1_to_f2_valid (f1_to_f2_valid),
    .f1_to_f2       (f1_to_f2),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_instr (imem_rsp_instr),
    .imem_rsp_fault (imem_rsp_fault),
    .f2_to_d_valid  (f2_to_d_valid),
    .f2_to_d        (f2_to_d),
    .dbg_state_o    (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        fl;
    logic        st;
    logic        f1v;
    logic [31:0] pc;
    logic        rv;
    logic [31:0] instr;
    logic        flt;
    logic        exp_rdy;
    logic [1:0]  exp_st;
    logic        exp_v;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_flt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic fl, logic st, logic f1v, logic [31:0] pc,
                              logic rv, logic [31:0] instr, logic flt,
                              logic exp_rdy, logic [1:0] exp_st, logic exp_v,
                              logic [31:0] exp_pc, logic [31:0] exp_instr,
                              logic exp_flt);
    vec_t v;
    v.fl = fl; v.st = st; v.f1v = f1v; v.pc = pc; v.rv = rv;
    v.instr = instr; v.flt = flt; v.exp_rdy = exp_rdy; v.exp_st = exp_st;
    v.exp_v = exp_v; v.exp_pc = exp_pc; v.exp_instr = exp_instr;
    v.exp_flt = exp_flt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // driver tasks
  task automatic drive(input logic fl, input logic st, input logic f1v,
                       input logic [31:0] pc, input logic rv,
                       input logic [31:0] instr, input logic flt);
    stage_flush    = fl;
    stage_stall    = st;
    f1_to_f2_valid = f1v;
    f1_to_f2.pc    = pc;
    imem_rsp_valid = rv;
    imem_rsp_instr = instr;
    imem_rsp_fault = flt;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] instr, input logic flt,
                           input logic [1:0] st);
    chk({tag, ".valid"}, {31'b0, f2_to_d_valid}, {31'b0, v});
    chk({tag, ".pc"},    f2_to_d.pc, pc);
    chk({tag, ".instr"}, f2_to_d.instr, instr);
    chk({tag, ".fault"}, {31'b0, f2_to_d.fetch_fault}, {31'b0, flt});
    chk({tag, ".state"}, {30'b0, dbg_state_o}, {30'b0, st});
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #12;
    check_out("reset", 1'b0, 32'h0, 32'h0, 1'b0, S_IDLE);
    chk("reset.ready", {31'b0, stage_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // fl st f1v pc rv instr flt | rdy state v pc instr flt
    vecs.push_back(mk(0,0,1,32'h1000,0,32'h0,0,        1,S_WAIT, 0,32'h0,   32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,1,32'h009433b3,0,    1,S_IDLE, 1,32'h1000,32'h009433b3,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0,0,           1,S_IDLE, 0,32'h1000,32'h009433b3,0));
    vecs.push_back(mk(0,0,1,32'h0,0,32'h0,0,           1,S_WAIT, 0,32'h1000,32'h009433b3,0));
    vecs.push_back(mk(0,0,1,32'h4,1,32'h11111111,0,    1,S_WAIT, 1,32'h0,   32'h11111111,0));
    vecs.push_back(mk(0,0,1,32'h8,1,32'h22222222,0,    1,S_WAIT, 1,32'h4,   32'h22222222,0));
    vecs.push_back(mk(0,0,1,32'h20,1,32'h33333333,0,   1,S_WAIT, 1,32'h8,   32'h33333333,0));
    vecs.push_back(mk(0,1,0,32'h0,1,32'hf8518293,0,    0,S_IDLE, 1,32'h8,   32'h33333333,0));
    vecs.push_back(mk(0,1,0,32'h0,0,32'h0,0,           0,S_IDLE, 1,32'h8,   32'h33333333,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0,0,           0,S_IDLE, 1,32'h20,  32'hf8518293,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0,0,           1,S_IDLE, 0,32'h20,  32'hf8518293,0));
    vecs.push_back(mk(0,0,1,32'h40,0,32'h0,0,          1,S_WAIT, 0,32'h20,  32'hf8518293,0));
    vecs.push_back(mk(1,0,0,32'h0,0,32'h0,0,           0,S_DRAIN,0,32'h20,  32'hf8518293,0));
    vecs.push_back(mk(0,0,0,32'h0,1,32'h12345678,0,    0,S_IDLE, 0,32'h20,  32'hf8518293,0));
    vecs.push_back(mk(0,0,1,32'h80,0,32'h0,0,          1,S_WAIT, 0,32'h20,  32'hf8518293,0));
    vecs.push_back(mk(0,0,0,32'h0,1,32'habcdef01,0,    1,S_IDLE, 1,32'h80,  32'habcdef01,0));
    vecs.push_back(mk(0,0,1,32'h100,0,32'h0,0,         1,S_WAIT, 0,32'h80,  32'habcdef01,0));
    vecs.push_back(mk(0,0,0,32'h0,1,32'hdeadbeef,1,    1,S_IDLE, 1,32'h100, 32'h00000013,1));
    vecs.push_back(mk(0,0,1,32'h200,0,32'h0,0,         1,S_WAIT, 0,32'h100, 32'h00000013,1));
    vecs.push_back(mk(1,1,1,32'h999,1,32'h55555555,0,  0,S_IDLE, 0,32'h100, 32'h00000013,1));
    vecs.push_back(mk(0,0,1,32'h204,0,32'h0,0,         1,S_WAIT, 0,32'h100, 32'h00000013,1));
    vecs.push_back(mk(0,0,1,32'h208,1,32'h66666666,0,  1,S_WAIT, 1,32'h204, 32'h66666666,0));
    vecs.push_back(mk(1,1,0,32'h0,0,32'h0,0,           0,S_DRAIN,0,32'h204, 32'h66666666,0));
    vecs.push_back(mk(1,0,0,32'h0,0,32'h0,0,           0,S_DRAIN,0,32'h204, 32'h66666666,0));
    vecs.push_back(mk(0,0,0,32'h0,1,32'h77777777,0,    0,S_IDLE, 0,32'h204, 32'h66666666,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0,0,           1,S_IDLE, 0,32'h204, 32'h66666666,0));
    vecs.push_back(mk(0,0,1,32'h300,0,32'h0,0,         1,S_WAIT, 0,32'h204, 32'h66666666,0));
    vecs.push_back(mk(0,1,0,32'h0,1,32'h88888888,0,    0,S_IDLE, 0,32'h204, 32'h66666666,0));
    vecs.push_back(mk(1,0,0,32'h0,0,32'h0,0,           0,S_IDLE, 0,32'h204, 32'h66666666,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0,0,           1,S_IDLE, 0,32'h204, 32'h66666666,0));

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].fl, vecs[i].st, vecs[i].f1v, vecs[i].pc, vecs[i].rv,
            vecs[i].instr, vecs[i].flt);
      #2;
      chk({tag, ".ready"}, {31'b0, stage_ready}, {31'b0, vecs[i].exp_rdy});
      tick();
      check_out(tag, vecs[i].exp_v, vecs[i].exp_pc, vecs[i].exp_instr,
                vecs[i].exp_flt, vecs[i].exp_st);
    end

    // asynchronous reset while a request is outstanding and output is valid
    drive(1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h404, 1'b1, 32'h99999999, 1'b0);
    tick();
    check_out("pre_rst", 1'b1, 32'h400, 32'h99999999, 1'b0, S_WAIT);
    idle_inputs();
    #1;
    rst = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 32'h0, 32'h0, 1'b0, S_IDLE);
    @(negedge clk);
    rst = 1'b0;
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
    #2;
    chk("post_rst.ready", {31'b0, stage_ready}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'haaaa5555, 1'b0);
    tick();
    check_out("post_rst", 1'b1, 32'h500, 32'haaaa5555, 1'b0, S_IDLE);
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no completion expected finish by 20000");
    $fatal(1, "timeout");
  end

endmodule
